// File: rtl/ahb_mtx_pkg.sv
// Shared AHB encodings and default-slave state type for the L1 bus-matrix input-stage decoder.
package ahb_mtx_pkg;

    localparam int ADDR_LSB = 10;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [1:0] HRESP_OKAY    = 2'b00;
    localparam logic [1:0] HRESP_ERROR   = 2'b01;

    typedef enum logic [1:0] {
        DFT_IDLE = 2'b00,
        DFT_ERR1 = 2'b01,
        DFT_ERR2 = 2'b10
    } dft_state_t;

    // NONSEQ and SEQ are the only transfer types that demand a response.
    function automatic logic trans_is_active(input logic [1:0] trans);
        return trans[1];
    endfunction

endpackage

// File: rtl/ahb_mtx_dec_param_if.sv
// Input-stage and output-stage signal bundle of one bus-matrix decoder.
interface ahb_mtx_dec_param_if #(
    parameter int NUM_OUT = 4,
    parameter int USER_W  = 32
);
    import ahb_mtx_pkg::*;

    logic                      HREADYS;
    logic                      sel_dec;
    logic [21:0]               decode_addr_dec;
    logic [1:0]                trans_dec;
    logic [NUM_OUT-1:0]        active_in;
    logic [NUM_OUT-1:0]        readyout_in;
    logic [2*NUM_OUT-1:0]      resp_in;
    logic [32*NUM_OUT-1:0]     rdata_in;
    logic [USER_W*NUM_OUT-1:0] ruser_in;

    logic [NUM_OUT-1:0]        sel_out;
    logic                      active_dec;
    logic                      HREADYOUTS;
    logic [1:0]                HRESPS;
    logic [31:0]               HRDATAS;
    logic [USER_W-1:0]         HRUSERS;

    modport slave (
        input  HREADYS, sel_dec, decode_addr_dec, trans_dec,
        input  active_in, readyout_in, resp_in, rdata_in, ruser_in,
        output sel_out, active_dec, HREADYOUTS, HRESPS, HRDATAS, HRUSERS
    );

    modport master (
        output HREADYS, sel_dec, decode_addr_dec, trans_dec,
        output active_in, readyout_in, resp_in, rdata_in, ruser_in,
        input  sel_out, active_dec, HREADYOUTS, HRESPS, HRDATAS, HRUSERS
    );

endinterface

// File: rtl/ahb_mtx_dft_slave.sv
// Default slave answering unmapped transfers with a two-cycle ERROR response.
// Optional decode-error log under DECERR_LOG_EN.
module ahb_mtx_dft_slave
    import ahb_mtx_pkg::*;
(
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        dft_req,
`ifdef DECERR_LOG_EN
    input  logic [21:0] decode_addr_dec,
    input  logic        err_clr,
    output logic        err_valid,
    output logic [21:0] err_addr,
`endif
    output logic        dft_ready,
    output logic [1:0]  dft_resp
);

    dft_state_t state_r;
    logic       ready_r;
    logic [1:0] resp_r;

    // Response FSM with registered HREADYOUT/HRESP.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_r <= DFT_IDLE;
            ready_r <= 1'b1;
            resp_r  <= HRESP_OKAY;
        end else begin
            case (state_r)
                DFT_IDLE, DFT_ERR2: begin
                    if (dft_req) begin
                        state_r <= DFT_ERR1;
                        ready_r <= 1'b0;
                        resp_r  <= HRESP_ERROR;
                    end else begin
                        state_r <= DFT_IDLE;
                        ready_r <= 1'b1;
                        resp_r  <= HRESP_OKAY;
                    end
                end
                DFT_ERR1: begin
                    state_r <= DFT_ERR2;
                    ready_r <= 1'b1;
                    resp_r  <= HRESP_ERROR;
                end
                default: begin
                    state_r <= DFT_IDLE;
                    ready_r <= 1'b1;
                    resp_r  <= HRESP_OKAY;
                end
            endcase
        end
    end

    assign dft_ready = ready_r;
    assign dft_resp  = resp_r;

`ifdef DECERR_LOG_EN
    logic        err_valid_r;
    logic [21:0] err_addr_r;
    logic        entry_s;

    // An ERR1 entry is a request seen while not already in the first error cycle.
    assign entry_s = dft_req && (state_r != DFT_ERR1);

    // First-error log; a capture takes precedence over a simultaneous clear.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            err_valid_r <= 1'b0;
            err_addr_r  <= 22'h000000;
        end else if (entry_s && !err_valid_r) begin
            err_valid_r <= 1'b1;
            err_addr_r  <= decode_addr_dec;
        end else if (err_clr) begin
            err_valid_r <= 1'b0;
        end else begin
            err_valid_r <= err_valid_r;
        end
    end

    assign err_valid = err_valid_r;
    assign err_addr  = err_addr_r;
`endif

endmodule

// File: rtl/ahb_mtx_dec_param.sv
// Input-stage address decoder of the L1 AHB bus matrix: region decode, data-phase mux, default slave.
// Optional feature macro: DECERR_LOG_EN (first decode-error address log).
module ahb_mtx_dec_param
    import ahb_mtx_pkg::*;
#(
    parameter int                    NUM_OUT     = 4,
    parameter int                    USER_W      = 32,
    parameter logic [22*NUM_OUT-1:0] REGION_BASE = {NUM_OUT{22'h000000}},
    parameter logic [22*NUM_OUT-1:0] REGION_MASK = {NUM_OUT{22'h3FFFE0}}
)(
    input  logic        HCLK,
    input  logic        HRESETn,
`ifdef DECERR_LOG_EN
    input  logic        err_clr,
    output logic        err_valid,
    output logic [21:0] err_addr,
`endif
    ahb_mtx_dec_param_if.slave bus
);

    localparam int TGT_W = NUM_OUT + 1;
    localparam int DFT   = NUM_OUT;
    localparam logic [TGT_W-1:0] TGT_RST = TGT_W'(1);

    logic [TGT_W-1:0]  match_oh_s;
    logic [TGT_W-1:0]  addr_oh_s;
    logic [TGT_W-1:0]  data_tgt_r;
    logic              hold_s;
    logic              dft_req_s;
    logic              dft_ready_s;
    logic [1:0]        dft_resp_s;
    logic              ready_s;
    logic [1:0]        resp_s;
    logic [31:0]       rdata_s;
    logic [USER_W-1:0] ruser_s;

    // An IDLE must not move the address target off a live output stage.
    assign hold_s = (bus.trans_dec == HTRANS_IDLE) && !data_tgt_r[DFT];

    // Region match with lowest-index priority; no hit falls through to the default slave.
    always_comb begin
        logic taken;
        logic hit;
        taken      = 1'b0;
        hit        = 1'b0;
        match_oh_s = {TGT_W{1'b0}};
        for (int i = 0; i < NUM_OUT; i++) begin
            hit           = ((bus.decode_addr_dec & REGION_MASK[22*i +: 22]) == REGION_BASE[22*i +: 22]);
            match_oh_s[i] = hit & ~taken;
            taken         = taken | hit;
        end
        match_oh_s[DFT] = ~taken;
        if (hold_s) begin
            addr_oh_s = data_tgt_r;
        end else begin
            addr_oh_s = match_oh_s;
        end
    end

    assign bus.sel_out    = bus.sel_dec ? addr_oh_s[NUM_OUT-1:0] : {NUM_OUT{1'b0}};
    assign bus.active_dec = (|(addr_oh_s[NUM_OUT-1:0] & bus.active_in)) | addr_oh_s[DFT];
    assign dft_req_s      = bus.sel_dec & addr_oh_s[DFT] & bus.HREADYS & trans_is_active(bus.trans_dec);

    // Data-phase target advances only when the current transfer completes.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            data_tgt_r <= TGT_RST;
        end else if (bus.HREADYS) begin
            data_tgt_r <= addr_oh_s;
        end else begin
            data_tgt_r <= data_tgt_r;
        end
    end

    // AND-OR mux over the one-hot data-phase target; the default-slave bit contributes no data.
    always_comb begin
        ready_s = 1'b0;
        resp_s  = 2'b00;
        rdata_s = 32'h00000000;
        ruser_s = {USER_W{1'b0}};
        for (int i = 0; i < NUM_OUT; i++) begin
            ready_s = ready_s | (data_tgt_r[i] & bus.readyout_in[i]);
            resp_s  = resp_s  | ({2{data_tgt_r[i]}} & bus.resp_in[2*i +: 2]);
            rdata_s = rdata_s | ({32{data_tgt_r[i]}} & bus.rdata_in[32*i +: 32]);
            ruser_s = ruser_s | ({USER_W{data_tgt_r[i]}} & bus.ruser_in[USER_W*i +: USER_W]);
        end
    end

    assign bus.HREADYOUTS = data_tgt_r[DFT] ? dft_ready_s : ready_s;
    assign bus.HRESPS     = data_tgt_r[DFT] ? dft_resp_s  : resp_s;
    assign bus.HRDATAS    = rdata_s;
    assign bus.HRUSERS    = ruser_s;

    ahb_mtx_dft_slave u_dft (
        .HCLK            (HCLK),
        .HRESETn         (HRESETn),
        .dft_req         (dft_req_s),
`ifdef DECERR_LOG_EN
        .decode_addr_dec (bus.decode_addr_dec),
        .err_clr         (err_clr),
        .err_valid       (err_valid),
        .err_addr        (err_addr),
`endif
        .dft_ready       (dft_ready_s),
        .dft_resp        (dft_resp_s)
    );

endmodule

// File: tb/tb_ahb_mtx_dec_param.sv
// Bench for ahb_mtx_dec_param: directed scenarios with literal expectations plus randomized traffic
// compared every cycle against a transaction-level reference model.
module tb_ahb_mtx_dec_param;
    import ahb_mtx_pkg::*;

    localparam int NUM_OUT = 4;
    localparam int USER_W  = 32;
    localparam logic [22*NUM_OUT-1:0] BASES = {22'h0000C0, 22'h000080, 22'h000040, 22'h000000};
    localparam logic [22*NUM_OUT-1:0] MASKS = {4{22'h3FFFC0}};

    logic HCLK    = 1'b0;
    logic HRESETn = 1'b0;
    always #5 HCLK = ~HCLK;

    ahb_mtx_dec_param_if #(.NUM_OUT(NUM_OUT), .USER_W(USER_W)) bus ();

`ifdef DECERR_LOG_EN
    logic        err_clr = 1'b0;
    logic        err_valid;
    logic [21:0] err_addr;
`endif

    ahb_mtx_dec_param #(
        .NUM_OUT(NUM_OUT), .USER_W(USER_W), .REGION_BASE(BASES), .REGION_MASK(MASKS)
    ) dut (
        .HCLK      (HCLK),
        .HRESETn   (HRESETn),
`ifdef DECERR_LOG_EN
        .err_clr   (err_clr),
        .err_valid (err_valid),
        .err_addr  (err_addr),
`endif
        .bus       (bus)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model: region table plus "who owns the data phase" and "how far into an error response".
    logic [21:0] base_a [NUM_OUT] = '{22'h000000, 22'h000040, 22'h000080, 22'h0000C0};
    logic [21:0] mask_a [NUM_OUT] = '{22'h3FFFC0, 22'h3FFFC0, 22'h3FFFC0, 22'h3FFFC0};
    int          m_tgt;     // NUM_OUT stands for the default slave
    int          m_err_cyc; // 0: no error response, 1/2: cycle of the error response
    bit          m_ev;
    logic [21:0] m_ea;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_tgt = 0; m_err_cyc = 0; m_ev = 1'b0; m_ea = 22'h0;
    endtask

    function automatic int region_of(input logic [21:0] a);
        for (int i = 0; i < NUM_OUT; i++)
            if ((a & mask_a[i]) == base_a[i]) return i;
        return NUM_OUT;
    endfunction

    function automatic int addr_target();
        if (bus.trans_dec == HTRANS_IDLE && m_tgt != NUM_OUT) return m_tgt;
        return region_of(bus.decode_addr_dec);
    endfunction

    function automatic logic model_ready();
        if (m_tgt == NUM_OUT) return (m_err_cyc != 1);
        return bus.readyout_in[m_tgt];
    endfunction

    task automatic model_compare();
        int          at;
        logic [3:0]  e_sel;
        logic        e_act;
        logic [1:0]  e_resp;
        logic [31:0] e_rd;
        logic [31:0] e_ru;
        at     = addr_target();
        e_sel  = (bus.sel_dec && at < NUM_OUT) ? 4'(1 << at) : 4'b0000;
        e_act  = (at == NUM_OUT) ? 1'b1 : bus.active_in[at];
        if (m_tgt == NUM_OUT) begin
            e_resp = (m_err_cyc == 0) ? HRESP_OKAY : HRESP_ERROR;
            e_rd   = 32'h0;
            e_ru   = 32'h0;
        end else begin
            e_resp = bus.resp_in[2*m_tgt +: 2];
            e_rd   = bus.rdata_in[32*m_tgt +: 32];
            e_ru   = bus.ruser_in[USER_W*m_tgt +: USER_W];
        end
        chk("sel_out", bus.sel_out, e_sel);
        chk("active_dec", bus.active_dec, e_act);
        chk("HREADYOUTS", bus.HREADYOUTS, model_ready());
        chk("HRESPS", bus.HRESPS, e_resp);
        chk("HRDATAS", bus.HRDATAS, e_rd);
        chk("HRUSERS", bus.HRUSERS, e_ru);
`ifdef DECERR_LOG_EN
        chk("err_valid", err_valid, m_ev);
        chk("err_addr", err_addr, m_ea);
`endif
    endtask

    task automatic model_update();
        int at;
        bit req;
        if (!HRESETn) begin
            model_reset();
        end else begin
            at  = addr_target();
            req = bus.sel_dec && at == NUM_OUT && bus.HREADYS && bus.trans_dec[1];
`ifdef DECERR_LOG_EN
            if (req && m_err_cyc != 1 && !m_ev) begin
                m_ev = 1'b1; m_ea = bus.decode_addr_dec;
            end else if (err_clr) begin
                m_ev = 1'b0;
            end
`endif
            if (m_err_cyc == 1) m_err_cyc = 2;
            else m_err_cyc = req ? 1 : 0;
            if (bus.HREADYS) m_tgt = at;
        end
    endtask

    // Called at a falling edge with inputs already driven.
    task automatic apply();
        #1;
        if (!HRESETn) model_reset();
        model_compare();
    endtask

    task automatic adv();
        @(posedge HCLK);
        model_update();
        @(negedge HCLK);
    endtask

    task automatic drive(input logic s, input logic [1:0] t, input logic [21:0] a, input logic hr);
        bus.sel_dec = s; bus.trans_dec = t; bus.decode_addr_dec = a; bus.HREADYS = hr;
    endtask

    initial begin
        model_reset();
        drive(1'b0, HTRANS_IDLE, 22'h0, 1'b1);
        bus.active_in   = 4'b0101;
        bus.readyout_in = 4'b0001;
        bus.resp_in     = 8'b00_00_00_01;
        bus.rdata_in    = {32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111};
        bus.ruser_in    = {32'hDDDD_0003, 32'hDDDD_0002, 32'hDDDD_0001, 32'hDDDD_0000};

        // Reset state
        @(negedge HCLK);
        apply();
        chk("rst_sel", bus.sel_out, 4'b0000);
        chk("rst_ready", bus.HREADYOUTS, 1'b1);
        chk("rst_resp", bus.HRESPS, 2'b01);
        chk("rst_rdata", bus.HRDATAS, 32'h1111_1111);
        chk("rst_ruser", bus.HRUSERS, 32'hDDDD_0000);
        adv();
        HRESETn = 1'b1;
        bus.readyout_in = 4'b1111;
        bus.resp_in     = 8'h00;

        // NONSEQ to port 1, data from port 1 next cycle
        drive(1'b1, HTRANS_NONSEQ, 22'h000040, 1'b1); apply();
        chk("p1_sel", bus.sel_out, 4'b0010); adv();
        drive(1'b1, HTRANS_IDLE, 22'h000040, 1'b1); apply();
        chk("p1_rdata", bus.HRDATAS, 32'h2222_2222); adv();

        // Back-to-back unmapped NONSEQ: ERR1,ERR2,ERR1,ERR2
        drive(1'b1, HTRANS_NONSEQ, 22'h200000, 1'b1); apply();
        chk("b2b_sel", bus.sel_out, 4'b0000); adv();
        drive(1'b1, HTRANS_NONSEQ, 22'h300000, 1'b0); apply();
        chk("b2b_rdy1", bus.HREADYOUTS, 1'b0); chk("b2b_resp1", bus.HRESPS, 2'b01); adv();
        drive(1'b1, HTRANS_NONSEQ, 22'h300000, 1'b1); apply();
        chk("b2b_rdy2", bus.HREADYOUTS, 1'b1); chk("b2b_resp2", bus.HRESPS, 2'b01); adv();
        drive(1'b1, HTRANS_IDLE, 22'h300000, 1'b0); apply();
        chk("b2b_rdy3", bus.HREADYOUTS, 1'b0); chk("b2b_resp3", bus.HRESPS, 2'b01); adv();
        drive(1'b1, HTRANS_IDLE, 22'h300000, 1'b1); apply();
        chk("b2b_rdy4", bus.HREADYOUTS, 1'b1); chk("b2b_resp4", bus.HRESPS, 2'b01);
`ifdef DECERR_LOG_EN
        chk("log_valid", err_valid, 1'b1); chk("log_addr", err_addr, 22'h200000);
        err_clr = 1'b1;
`endif
        adv();
        // IDLE to unmapped region: zero-wait OKAY
        drive(1'b1, HTRANS_IDLE, 22'h300000, 1'b1); apply();
        chk("idle_dft_rdy", bus.HREADYOUTS, 1'b1); chk("idle_dft_resp", bus.HRESPS, 2'b00);
`ifdef DECERR_LOG_EN
        err_clr = 1'b0;
        chk("log_cleared", err_valid, 1'b0);
`endif
        adv();

        // Single unmapped NONSEQ: 0/ERROR, 1/ERROR, then OKAY
        drive(1'b1, HTRANS_NONSEQ, 22'h200000, 1'b1); apply();
        chk("err_sel", bus.sel_out, 4'b0000); adv();
        drive(1'b1, HTRANS_IDLE, 22'h200000, 1'b0); apply();
        chk("err_rdy1", bus.HREADYOUTS, 1'b0); chk("err_resp1", bus.HRESPS, 2'b01); adv();
        drive(1'b1, HTRANS_IDLE, 22'h200000, 1'b1); apply();
        chk("err_rdy2", bus.HREADYOUTS, 1'b1); chk("err_resp2", bus.HRESPS, 2'b01); adv();
        drive(1'b1, HTRANS_NONSEQ, 22'h000000, 1'b1); apply();
        chk("err_okay", bus.HRESPS, 2'b00); adv();

        // Port 2 data phase stalled while the next address targets port 0
        drive(1'b1, HTRANS_NONSEQ, 22'h000080, 1'b1); apply(); adv();
        bus.readyout_in = 4'b1011;
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, HTRANS_NONSEQ, 22'h000000, 1'b0); apply();
            chk("stall_sel", bus.sel_out, 4'b0001);
            chk("stall_rdy", bus.HREADYOUTS, 1'b0);
            chk("stall_rdata", bus.HRDATAS, 32'h3333_3333);
            adv();
        end
        bus.readyout_in = 4'b1111;
        drive(1'b1, HTRANS_NONSEQ, 22'h000000, 1'b1); apply();
        chk("stall_done", bus.HRDATAS, 32'h3333_3333); adv();
        drive(1'b1, HTRANS_IDLE, 22'h000000, 1'b1); apply();
        chk("after_stall", bus.HRDATAS, 32'h1111_1111); adv();

        // IDLE after port 3 keeps address target at 3
        drive(1'b1, HTRANS_NONSEQ, 22'h0000C0, 1'b1); apply(); adv();
        drive(1'b1, HTRANS_IDLE, 22'h000000, 1'b1); apply();
        chk("idle_hold_sel", bus.sel_out, 4'b1000); adv();
        drive(1'b1, HTRANS_IDLE, 22'h000000, 1'b1); apply();
        chk("idle_hold_rdata", bus.HRDATAS, 32'h4444_4444); adv();

        // Reset asserted during ERR1
        drive(1'b1, HTRANS_NONSEQ, 22'h2AAAAA, 1'b1); apply(); adv();
        bus.readyout_in = 4'b0001;
        bus.resp_in     = 8'b01_01_01_00;
        drive(1'b1, HTRANS_IDLE, 22'h2AAAAA, 1'b0); apply();
        chk("mid_err1", bus.HREADYOUTS, 1'b0);
        #1 HRESETn = 1'b0;
        #1 model_reset();
        model_compare();
        chk("mid_rst_rdy", bus.HREADYOUTS, 1'b1);
        chk("mid_rst_resp", bus.HRESPS, 2'b00);
`ifdef DECERR_LOG_EN
        chk("mid_rst_log", err_valid, 1'b0);
`endif
        adv();
        HRESETn = 1'b1;

        // Randomized traffic against the model
        for (int n = 0; n < 1500; n++) begin
            HRESETn = (n % 400 != 399);
            bus.sel_dec   = ($urandom_range(0, 7) != 0);
            bus.trans_dec = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 3))
                0, 1:    bus.decode_addr_dec = 22'($urandom_range(0, 3) * 64 + $urandom_range(0, 63));
                2:       bus.decode_addr_dec = 22'h200000 | 22'($urandom);
                default: bus.decode_addr_dec = 22'($urandom);
            endcase
            bus.active_in   = 4'($urandom);
            bus.readyout_in = ($urandom_range(0, 3) != 0) ? 4'hF : 4'($urandom);
            bus.resp_in     = 8'($urandom) & 8'h55;
            bus.rdata_in    = {$urandom, $urandom, $urandom, $urandom};
            bus.ruser_in    = {$urandom, $urandom, $urandom, $urandom};
`ifdef DECERR_LOG_EN
            err_clr = ($urandom_range(0, 9) == 0);
`endif
            if (!HRESETn) model_reset();
            bus.HREADYS = ($urandom_range(0, 4) != 0) ? model_ready() : 1'($urandom);
            apply();
            adv();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
